// File: rtl/frame_sequencer_if.sv
// Frame-level control bundle between the capture side and the frame sequencer.
// The capture side (master) drives requests, pixel strobes and stage done pulses.
interface frame_sequencer_if #(
  parameter int unsigned NumStages = 3
);
  logic                 frame_req;
  logic                 valid;
  logic [NumStages-1:0] done;
  logic                 pixel_en;
  logic                 new_frame;
  logic [NumStages-1:0] stage_reset;
  logic                 busy;
  logic                 frame_done;
  logic [15:0]          frame_cnt;
  logic                 dropped;
  logic                 error;

  modport master (
    output frame_req, valid, done,
    input  pixel_en, new_frame, stage_reset, busy, frame_done, frame_cnt, dropped, error
  );

  modport slave (
    input  frame_req, valid, done,
    output pixel_en, new_frame, stage_reset, busy, frame_done, frame_cnt, dropped, error
  );
endinterface

// File: rtl/frame_sequencer.sv
// Sequences one frame through the demosaic/filter/rgb2ycc chain: clears the stages,
// gates exactly Width*Height pixels in, then waits for every stage's done pulse.
module frame_sequencer #(
  parameter int unsigned Width       = 320,
  parameter int unsigned Height      = 240,
  parameter int unsigned NumStages   = 3,
  parameter int unsigned ClearCycles = 2,
  parameter int unsigned Timeout     = 65536
) (
  input logic              clk,
  input logic              rst_n,
  frame_sequencer_if.slave bus
);

  localparam int unsigned NumPix = Width * Height;
  localparam int unsigned PixW   = (NumPix > 1) ? $clog2(NumPix) : 1;
  localparam int unsigned ClrW   = (ClearCycles > 1) ? $clog2(ClearCycles) : 1;
  localparam int unsigned TmoW   = (Timeout > 1) ? $clog2(Timeout) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StArm,
    StRun,
    StDrain,
    StDone,
    StError
  } state_e;

  state_e               state_q;
  logic [ClrW-1:0]      clear_cnt_q;
  logic [PixW-1:0]      pix_cnt_q;
  logic [TmoW-1:0]      tmo_cnt_q;
  logic [NumStages-1:0] done_mask_q;
  logic                 pending_q;

  logic                 pixel_en_q;
  logic                 new_frame_q;
  logic [NumStages-1:0] stage_reset_q;
  logic                 busy_q;
  logic                 frame_done_q;
  logic [15:0]          frame_cnt_q;
  logic                 dropped_q;
  logic                 error_q;

  logic                 mid_frame;
  assign mid_frame = (state_q == StClear) || (state_q == StArm) ||
                     (state_q == StRun) || (state_q == StDrain);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      clear_cnt_q   <= '0;
      pix_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      done_mask_q   <= '0;
      pending_q     <= 1'b0;
      pixel_en_q    <= 1'b0;
      new_frame_q   <= 1'b0;
      stage_reset_q <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
      dropped_q     <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      new_frame_q  <= 1'b0;
      frame_done_q <= 1'b0;
      dropped_q    <= 1'b0;

      // One-deep request queue while a frame is in flight; DONE handles its own.
      if (mid_frame && bus.frame_req) begin
        if (pending_q) begin
          dropped_q <= 1'b1;
        end else begin
          pending_q <= 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (bus.frame_req) begin
            state_q       <= StClear;
            clear_cnt_q   <= '0;
            pix_cnt_q     <= '0;
            done_mask_q   <= '0;
            stage_reset_q <= '1;
            busy_q        <= 1'b1;
            error_q       <= 1'b0;
          end
        end

        StClear: begin
          if (clear_cnt_q == ClrW'(ClearCycles - 1)) begin
            state_q       <= StArm;
            stage_reset_q <= '0;
            new_frame_q   <= 1'b1;
            done_mask_q   <= bus.done;
          end else begin
            clear_cnt_q <= clear_cnt_q + 1'b1;
            done_mask_q <= '0;
          end
        end

        StArm: begin
          state_q     <= StRun;
          pixel_en_q  <= 1'b1;
          done_mask_q <= done_mask_q | bus.done;
        end

        StRun: begin
          done_mask_q   <= done_mask_q | bus.done;
          stage_reset_q <= bus.done;
          if (bus.valid) begin
            if (pix_cnt_q == PixW'(NumPix - 1)) begin
              state_q    <= StDrain;
              pixel_en_q <= 1'b0;
              tmo_cnt_q  <= '0;
            end else begin
              pix_cnt_q <= pix_cnt_q + 1'b1;
            end
          end
        end

        StDrain: begin
          done_mask_q   <= done_mask_q | bus.done;
          stage_reset_q <= bus.done;
          if ((done_mask_q | bus.done) == '1) begin
            state_q      <= StDone;
            frame_done_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_q + 16'd1;
          end else if (tmo_cnt_q == TmoW'(Timeout - 1)) begin
            state_q       <= StError;
            error_q       <= 1'b1;
            stage_reset_q <= '1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end

        StDone: begin
          // A request arriving as the pending one is consumed becomes the new pending.
          if (pending_q || bus.frame_req) begin
            state_q       <= StClear;
            pending_q     <= pending_q && bus.frame_req;
            clear_cnt_q   <= '0;
            pix_cnt_q     <= '0;
            done_mask_q   <= '0;
            stage_reset_q <= '1;
            busy_q        <= 1'b1;
          end else begin
            state_q       <= StIdle;
            stage_reset_q <= '0;
            busy_q        <= 1'b0;
          end
        end

        StError: begin
          if (bus.frame_req) begin
            state_q       <= StClear;
            clear_cnt_q   <= '0;
            pix_cnt_q     <= '0;
            done_mask_q   <= '0;
            stage_reset_q <= '1;
            error_q       <= 1'b0;
          end
        end

        default: begin
          state_q       <= StIdle;
          pixel_en_q    <= 1'b0;
          stage_reset_q <= '0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pixel_en    = pixel_en_q;
  assign bus.new_frame   = new_frame_q;
  assign bus.stage_reset = stage_reset_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.dropped     = dropped_q;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with a 4x2 frame, 2 clear cycles and a 16-cycle timeout.
module tb_frame_sequencer;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  frame_sequencer_if #(.NumStages(3)) bus ();

  frame_sequencer #(
    .Width      (4),
    .Height     (2),
    .NumStages  (3),
    .ClearCycles(2),
    .Timeout    (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Ends at the negedge of the first RUN cycle.
  task automatic start_frame(input bit do_req);
    if (do_req) bus.frame_req = 1'b1;
    step();
    bus.frame_req = 1'b0;
    check("clr1_sr", bus.stage_reset, 3'b111);
    check("clr1_busy", bus.busy, 1'b1);
    check("clr1_err", bus.error, 1'b0);
    step();
    check("clr2_sr", bus.stage_reset, 3'b111);
    check("clr2_nf", bus.new_frame, 1'b0);
    step();
    check("arm_nf", bus.new_frame, 1'b1);
    check("arm_sr", bus.stage_reset, 3'b000);
    check("arm_pe", bus.pixel_en, 1'b0);
    step();
    check("run_pe", bus.pixel_en, 1'b1);
    check("run_nf", bus.new_frame, 1'b0);
  endtask

  task automatic feed(input bit gap, input int req_a, input int req_b, input int early_at,
                      output int en, output int acc, output int drop_at);
    en = 0;
    acc = 0;
    drop_at = -1;
    for (int i = 0; i < 64; i++) begin
      if (!bus.pixel_en) break;
      if (bus.dropped) drop_at = i;
      if (early_at >= 0 && i == early_at + 1) check("early_sr", bus.stage_reset, 3'b001);
      if (early_at >= 0 && i == early_at + 2) check("early_sr_off", bus.stage_reset, 3'b000);
      bus.valid     = gap ? (i % 2 == 1) : 1'b1;
      bus.frame_req = (i == req_a) || (i == req_b);
      bus.done      = (i == early_at) ? 3'b001 : 3'b000;
      en++;
      if (bus.valid) acc++;
      step();
    end
    bus.valid     = 1'b0;
    bus.frame_req = 1'b0;
    bus.done      = 3'b000;
  endtask

  task automatic drain_all();
    check("drain_pe", bus.pixel_en, 1'b0);
    bus.done = 3'b111;
    step();
    bus.done = 3'b000;
    check("drain_fd", bus.frame_done, 1'b1);
  endtask

  initial begin
    int en, acc, drop_at, dc;
    n_checks      = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    bus.frame_req = 1'b0;
    bus.valid     = 1'b0;
    bus.done      = 3'b000;
    step();
    step();
    check("rst_pe", bus.pixel_en, 1'b0);
    check("rst_nf", bus.new_frame, 1'b0);
    check("rst_sr", bus.stage_reset, 3'b000);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_fd", bus.frame_done, 1'b0);
    check("rst_cnt", bus.frame_cnt, 16'd0);
    check("rst_drop", bus.dropped, 1'b0);
    check("rst_err", bus.error, 1'b0);
    rst_n = 1'b1;
    step();

    // Nominal frame with staggered done pulses.
    start_frame(1'b1);
    feed(1'b0, -1, -1, -1, en, acc, drop_at);
    check("nom_en", en, 8);
    check("nom_acc", acc, 8);
    check("nom_drain_busy", bus.busy, 1'b1);
    bus.done = 3'b001;
    step();
    check("nom_sr0", bus.stage_reset, 3'b001);
    bus.done = 3'b010;
    step();
    check("nom_sr1", bus.stage_reset, 3'b010);
    check("nom_fd_early", bus.frame_done, 1'b0);
    bus.done = 3'b100;
    step();
    bus.done = 3'b000;
    check("nom_fd", bus.frame_done, 1'b1);
    check("nom_cnt", bus.frame_cnt, 16'd1);
    step();
    check("nom_fd_off", bus.frame_done, 1'b0);
    check("nom_idle", bus.busy, 1'b0);
    check("nom_sr_idle", bus.stage_reset, 3'b000);

    // Gapped input; valid also held high through CLEAR/ARM, which must not count.
    do_reset();
    bus.valid = 1'b1;
    start_frame(1'b1);
    feed(1'b1, -1, -1, -1, en, acc, drop_at);
    check("gap_en", en, 16);
    check("gap_acc", acc, 8);
    drain_all();
    check("gap_cnt", bus.frame_cnt, 16'd1);

    // Timeout: stage 2 never finishes.
    do_reset();
    start_frame(1'b1);
    feed(1'b0, -1, -1, -1, en, acc, drop_at);
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.error) break;
      dc++;
      bus.done = (i == 0) ? 3'b001 : ((i == 1) ? 3'b010 : 3'b000);
      step();
    end
    bus.done = 3'b000;
    check("tmo_cycles", dc, 16);
    check("tmo_err", bus.error, 1'b1);
    check("tmo_sr", bus.stage_reset, 3'b111);
    check("tmo_fd", bus.frame_done, 1'b0);
    step();
    step();
    check("tmo_err_held", bus.error, 1'b1);
    check("tmo_sr_held", bus.stage_reset, 3'b111);
    start_frame(1'b1);
    feed(1'b0, -1, -1, -1, en, acc, drop_at);
    check("tmo_re_acc", acc, 8);
    drain_all();
    check("tmo_re_cnt", bus.frame_cnt, 16'd1);

    // Back-to-back with a dropped third request.
    do_reset();
    start_frame(1'b1);
    feed(1'b0, 2, 4, -1, en, acc, drop_at);
    check("b2b_drop_at", drop_at, 5);
    drain_all();
    check("b2b_cnt1", bus.frame_cnt, 16'd1);
    start_frame(1'b0);
    feed(1'b0, -1, -1, -1, en, acc, drop_at);
    check("b2b_acc2", acc, 8);
    check("b2b_nodrop", drop_at, -1);
    drain_all();
    check("b2b_cnt2", bus.frame_cnt, 16'd2);
    step();
    check("b2b_idle", bus.busy, 1'b0);

    // Early done from stage 0 during RUN.
    do_reset();
    start_frame(1'b1);
    feed(1'b0, -1, -1, 2, en, acc, drop_at);
    check("early_acc", acc, 8);
    bus.done = 3'b110;
    step();
    bus.done = 3'b000;
    check("early_fd", bus.frame_done, 1'b1);
    check("early_cnt", bus.frame_cnt, 16'd1);

    // Async reset after three pixels.
    do_reset();
    start_frame(1'b1);
    bus.valid = 1'b1;
    step();
    step();
    step();
    rst_n     = 1'b0;
    bus.valid = 1'b0;
    #1;
    check("arst_pe", bus.pixel_en, 1'b0);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_sr", bus.stage_reset, 3'b000);
    check("arst_cnt", bus.frame_cnt, 16'd0);
    step();
    rst_n = 1'b1;
    step();
    check("arst_fd", bus.frame_done, 1'b0);
    start_frame(1'b1);
    feed(1'b0, -1, -1, -1, en, acc, drop_at);
    check("arst_en", en, 8);
    check("arst_acc", acc, 8);
    drain_all();
    check("arst_cnt1", bus.frame_cnt, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
